prover_v_update: RTL

- Per-round V-table update feeding prover_shuffle_v in the sumcheck prover.
- For each gate i, computes the line restriction v_tau[i] = v_0[i] + tau*(v_1[i] - v_0[i]) mod `F_Q.
- Result array becomes the next round's v_*_in.
- One bit-serial modular multiplier is shared across all gates, processed sequentially; en/restart/ready handshake matches the shuffle stage so the two chain directly.

---
 rtl/prover_v_update.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/prover_v_update.sv
// Per-round V-table line restriction: v_tau[i] = v_0[i] + tau*(v_1[i]-v_0[i]) mod F_Q, one gate at a time.
// Optional PROVER_V_UPDATE_SKIPZERO_EN skips the multiply when v_1[i]==v_0[i].
`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_Q
`define F_Q 65521
`endif

module prover_v_update #(
  parameter int unsigned ngates = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              restart,
  input  logic [`F_NBITS-1:0]               tau,
  input  logic [ngates-1:0][`F_NBITS-1:0]   v_0,
  input  logic [ngates-1:0][`F_NBITS-1:0]   v_1,
  output logic                              ready,
  output logic                              ready_pulse,
  output logic [ngates-1:0][`F_NBITS-1:0]   v_tau
);

  localparam int unsigned W    = `F_NBITS;
  localparam int unsigned IdxW = (ngates > 1) ? $clog2(ngates) : 1;
  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] Q   = W'(`F_Q);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSub  = 2'd1;
  localparam logic [1:0] StMul  = 2'd2;
  localparam logic [1:0] StAdd  = 2'd3;

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = a - b;
    if (a < b) r = r + Q;
    return r;
  endfunction

  logic [1:0]                      state_q, state_d;
  logic [W-1:0]                    tau_q, tau_d;
  logic [IdxW-1:0]                 idx_q, idx_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic [W-1:0]                    acc_q, acc_d;
  logic [W-1:0]                    d_q, d_d;
  logic [ngates-1:0][W-1:0]        v_tau_q, v_tau_d;
  logic                            ready_q, ready_d;
  logic                            ready_pulse_q, ready_pulse_d;
  logic [W-1:0]                    dbl;
  logic                            last_gate;

  assign last_gate = (idx_q == IdxW'(ngates - 1));

  always_comb begin
    state_d       = state_q;
    tau_d         = tau_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    d_d           = d_q;
    v_tau_d       = v_tau_q;
    ready_d       = ready_q;
    ready_pulse_d = 1'b0;
    dbl           = mod_add(acc_q, acc_q);

    case (state_q)
      StIdle: begin
        if (en) begin
          tau_d   = tau;
          idx_d   = '0;
          ready_d = 1'b0;
          state_d = StSub;
        end
      end
      StSub: begin
        d_d     = mod_sub(v_1[idx_q], v_0[idx_q]);
        acc_d   = '0;
        cnt_d   = CntW'(W - 1);
`ifdef PROVER_V_UPDATE_SKIPZERO_EN
        // Zero slope: acc stays 0 so the add stage just copies v_0.
        state_d = (v_1[idx_q] == v_0[idx_q]) ? StAdd : StMul;
`else
        state_d = StMul;
`endif
      end
      StMul: begin
        // MSB-first double-and-add over the latched challenge.
        acc_d = tau_q[cnt_q] ? mod_add(dbl, d_q) : dbl;
        if (cnt_q == '0) state_d = StAdd;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StAdd: begin
        v_tau_d[idx_q] = mod_add(acc_q, v_0[idx_q]);
        if (last_gate) begin
          ready_d       = 1'b1;
          ready_pulse_d = 1'b1;
          state_d       = StIdle;
        end else begin
          idx_d   = idx_q + IdxW'(1);
          state_d = StSub;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort from any busy state; wins over the last-gate completion.
    if (state_q != StIdle && en && restart) begin
      tau_d         = tau;
      idx_d         = '0;
      ready_d       = 1'b0;
      ready_pulse_d = 1'b0;
      state_d       = StSub;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      tau_q         <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      d_q           <= '0;
      v_tau_q       <= '0;
      ready_q       <= 1'b0;
      ready_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tau_q         <= tau_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      d_q           <= d_d;
      v_tau_q       <= v_tau_d;
      ready_q       <= ready_d;
      ready_pulse_q <= ready_pulse_d;
    end
  end

  assign ready       = ready_q;
  assign ready_pulse = ready_pulse_q;
  assign v_tau       = v_tau_q;

endmodule
